program_loader: RTL and testbench

//  Upstream feeder of the MIPS instruction memory. Takes a byte stream from the UART receiver, packs

---
 rtl/program_loader.sv | 191 +++++++++++++++++++
 tb/tb_program_loader.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
`default_nettype none
// ============================================================================
//  Module      : program_loader
//  Description : Packs a UART byte stream big-endian into 32-bit words and
//                writes them to instruction memory from address 0 until the
//                first HALT word, then releases the CPU. Optional trailing
//                checksum byte is enabled by defining LOADER_CHECKSUM_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module program_loader #(
    parameter int len_addr  = 7,
    parameter int len_data  = 32,
    parameter int ram_depth = 128
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                rx_done,
    input  logic [7:0]          rx_data,
    output logic                Wr,
    output logic [len_addr-1:0] Addr,
    output logic [len_data-1:0] In_Data,
    output logic                cpu_ena,
    output logic                load_done,
    output logic                err_ovf,
    output logic [len_addr:0]   word_cnt
`ifdef LOADER_CHECKSUM_EN
    ,
    output logic                chk_err
`endif
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RECV  = 3'd1,
        S_SETUP = 3'd2,
        S_WRITE = 3'd3,
        S_HOLD  = 3'd4,
        S_DONE  = 3'd5
`ifdef LOADER_CHECKSUM_EN
        ,
        S_CHECK = 3'd6
`endif
    } state_t;

    localparam logic [5:0]          c_HALT_OP   = 6'b111111;
    localparam logic [len_addr-1:0] c_LAST_ADDR = len_addr'(ram_depth - 1);
    localparam logic [len_addr-1:0] c_ADDR_ONE  = len_addr'(1);
    localparam logic [len_addr:0]   c_CNT_ONE   = (len_addr + 1)'(1);

    state_t                state_q, state_d;
    logic [1:0]            byte_cnt_q, byte_cnt_d;
    logic [len_data-1:0]   shift_q, shift_d;
    logic                  wr_q, wr_d;
    logic [len_addr-1:0]   addr_q, addr_d;
    logic [len_data-1:0]   data_q, data_d;
    logic [len_addr:0]     word_cnt_q, word_cnt_d;
    logic                  err_ovf_q, err_ovf_d;
    logic                  load_done_q;
    logic                  cpu_ena_q;
    logic                  w_accept;
    logic                  w_word_full;
    logic                  w_release;

`ifdef LOADER_CHECKSUM_EN
    logic [7:0]            xor_q, xor_d;
    logic                  chk_err_q, chk_err_d;

    assign w_accept  = rx_done && (state_q != S_DONE) && (state_q != S_CHECK);
    assign w_release = !chk_err_q;
    assign chk_err   = chk_err_q;
`else
    assign w_accept  = rx_done && (state_q != S_DONE);
    assign w_release = 1'b1;
`endif

    // The shift register keeps collecting while a word is being written.
    assign w_word_full = w_accept && (byte_cnt_q == 2'd3);

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        shift_d    = shift_q;
        addr_d     = addr_q;
        data_d     = data_q;
        word_cnt_d = word_cnt_q;
        err_ovf_d  = err_ovf_q;
`ifdef LOADER_CHECKSUM_EN
        xor_d      = xor_q;
        chk_err_d  = chk_err_q;
`endif

        if (w_accept) begin
            shift_d    = {shift_q[len_data-9:0], rx_data};
            byte_cnt_d = byte_cnt_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
            xor_d      = xor_q ^ rx_data;
`endif
        end

        unique case (state_q)
            S_IDLE: begin
                if (w_accept) state_d = S_RECV;
            end
            S_RECV: begin
                // Word is presented a full cycle before Wr rises.
                if (w_word_full) begin
                    state_d = S_SETUP;
                    data_d  = shift_d;
                end
            end
            S_SETUP: state_d = S_WRITE;
            S_WRITE: state_d = S_HOLD;
            S_HOLD: begin
                word_cnt_d = word_cnt_q + c_CNT_ONE;
                if (data_q[len_data-1 -: 6] == c_HALT_OP) begin
`ifdef LOADER_CHECKSUM_EN
                    state_d = S_CHECK;
`else
                    state_d = S_DONE;
`endif
                end else if (addr_q == c_LAST_ADDR) begin
                    err_ovf_d = 1'b1;
                    state_d   = S_DONE;
                end else begin
                    addr_d  = addr_q + c_ADDR_ONE;
                    state_d = S_RECV;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            S_CHECK: begin
                if (rx_done) begin
                    chk_err_d = (rx_data != xor_q);
                    state_d   = S_DONE;
                end
            end
`endif
            S_DONE: state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase

        // A word completed while the previous one is still being written is lost.
        if (w_word_full && ((state_q == S_SETUP) || (state_q == S_WRITE) || (state_q == S_HOLD)))
            err_ovf_d = 1'b1;
    end

    assign wr_d = (state_d == S_WRITE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            byte_cnt_q  <= 2'd0;
            shift_q     <= '0;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            word_cnt_q  <= '0;
            err_ovf_q   <= 1'b0;
            load_done_q <= 1'b0;
            cpu_ena_q   <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            xor_q       <= 8'd0;
            chk_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            byte_cnt_q  <= byte_cnt_d;
            shift_q     <= shift_d;
            wr_q        <= wr_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            word_cnt_q  <= word_cnt_d;
            err_ovf_q   <= err_ovf_d;
            load_done_q <= (state_q == S_DONE);
            cpu_ena_q   <= (state_q == S_DONE) && w_release;
`ifdef LOADER_CHECKSUM_EN
            xor_q       <= xor_d;
            chk_err_q   <= chk_err_d;
`endif
        end
    end

    assign Wr        = wr_q;
    assign Addr      = addr_q;
    assign In_Data   = data_q;
    assign cpu_ena   = cpu_ena_q;
    assign load_done = load_done_q;
    assign err_ovf   = err_ovf_q;
    assign word_cnt  = word_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_program_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_program_loader
//  Description : Randomised directed bench for program_loader; the expected
//                memory image and write timing come from a word-level model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_program_loader;

    logic        clk;
    logic        reset;
    logic        rx_done;
    logic [7:0]  rx_data;
    logic        Wr;
    logic [6:0]  Addr;
    logic [31:0] In_Data;
    logic        cpu_ena;
    logic        load_done;
    logic        err_ovf;
    logic [7:0]  word_cnt;
`ifdef LOADER_CHECKSUM_EN
    logic        chk_err;
`endif

    program_loader #(
        .len_addr  (7),
        .len_data  (32),
        .ram_depth (128)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rx_done   (rx_done),
        .rx_data   (rx_data),
        .Wr        (Wr),
        .Addr      (Addr),
        .In_Data   (In_Data),
        .cpu_ena   (cpu_ena),
        .load_done (load_done),
        .err_ovf   (err_ovf),
        .word_cnt  (word_cnt)
`ifdef LOADER_CHECKSUM_EN
        ,
        .chk_err   (chk_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    logic [31:0] prog[$];
    int          exp_cyc[256];
    int          push_idx = 0;
    int          wr_seq   = 0;
    logic [6:0]  log_addr[256];
    logic [31:0] log_data[256];
    logic        prev_wr  = 1'b0;
    logic [6:0]  p_addr   = '0;
    logic [31:0] p_data   = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    // Memory-side observer: logs writes and checks the Wr window.
    always @(negedge clk) begin
        if (reset) begin
            wr_seq <= 0;
        end else if (Wr) begin
            check("wr_width", 32'(prev_wr), 32'd0);
            check("wr_setup_addr", 32'(Addr), 32'(p_addr));
            check("wr_setup_data", In_Data, p_data);
            check("wr_expected", 32'(wr_seq < push_idx), 32'd1);
            if (wr_seq < push_idx)
                check("wr_latency", cyc, exp_cyc[wr_seq & 255]);
            log_addr[wr_seq & 255] <= Addr;
            log_data[wr_seq & 255] <= In_Data;
            wr_seq <= wr_seq + 1;
        end else if (prev_wr) begin
            check("wr_hold_addr", 32'(Addr), 32'(p_addr));
            check("wr_hold_data", In_Data, p_data);
        end
        prev_wr <= Wr;
        p_addr  <= Addr;
        p_data  <= In_Data;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Strobe one byte; a written word's 4th byte records when Wr must rise.
    task automatic send_byte(input logic [7:0] b, input bit push);
        rx_done = 1'b1;
        rx_data = b;
        if (push) begin
            exp_cyc[push_idx & 255] = cyc + 2;
            push_idx++;
        end
        tick(1);
        rx_done = 1'b0;
        tick(int'($urandom_range(0, 2)));
    endtask

    task automatic check_reset_vals();
        check("rst_wr", 32'(Wr), 32'd0);
        check("rst_addr", 32'(Addr), 32'd0);
        check("rst_data", In_Data, 32'd0);
        check("rst_cpu_ena", 32'(cpu_ena), 32'd0);
        check("rst_load_done", 32'(load_done), 32'd0);
        check("rst_err_ovf", 32'(err_ovf), 32'd0);
        check("rst_word_cnt", 32'(word_cnt), 32'd0);
`ifdef LOADER_CHECKSUM_EN
        check("rst_chk_err", 32'(chk_err), 32'd0);
`endif
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        rx_done  = 1'b0;
        push_idx = 0;
        tick(2);
        check_reset_vals();
        reset = 1'b0;
        tick(1);
    endtask

    // Model: words land at 0,1,2.. until the first HALT or the last address.
    task automatic load_prog(input bit bad_chk, output int n_wr);
        logic [7:0] x;
        logic       halted;
        n_wr   = 0;
        halted = 1'b0;
        x      = 8'd0;
        foreach (prog[i]) begin
            if (!halted && n_wr < 128) begin
                n_wr++;
                halted = (prog[i][31:26] == 6'h3F);
            end
        end
        for (int i = 0; i < n_wr; i++) begin
            for (int k = 3; k >= 0; k--) begin
                logic [31:0] w;
                w = prog[i];
                x = x ^ w[k*8 +: 8];
                send_byte(w[k*8 +: 8], k == 0);
            end
        end
`ifdef LOADER_CHECKSUM_EN
        if (halted) begin
            tick(5);
            send_byte(bad_chk ? ~x : x, 1'b0);
        end
`else
        if (bad_chk && halted) x = ~x;
`endif
        for (int k = 0; k < 200 && !load_done; k++) tick(1);
        check("load_done", 32'(load_done), 32'd1);
        tick(2);
    endtask

    task automatic verify(input int n_wr, input logic exp_ovf, input logic exp_cpu);
        check("cpu_ena", 32'(cpu_ena), 32'(exp_cpu));
        check("err_ovf", 32'(err_ovf), 32'(exp_ovf));
        check("word_cnt", 32'(word_cnt), n_wr);
        check("final_addr", 32'(Addr), n_wr - 1);
        check("wr_count", wr_seq, n_wr);
        for (int i = 0; i < n_wr && i < wr_seq; i++) begin
            check("mem_addr", 32'(log_addr[i]), i);
            check("mem_data", log_data[i], prog[i]);
        end
    endtask

    function automatic logic [31:0] rand_word(input bit halt);
        logic [31:0] w;
        w = $urandom;
        if (halt) w[31:26] = 6'h3F;
        else if (w[31:26] == 6'h3F) w[26] = 1'b0;
        return w;
    endfunction

    initial begin
        int n_wr;
        int seen_wr;
        logic [6:0] seen_addr;
        reset   = 1'b1;
        rx_done = 1'b0;
        rx_data = 8'd0;
        tick(3);
        do_reset();

        // Reference program from the datasheet example.
        prog = {32'h20010005, 32'hFC000000};
        load_prog(1'b0, n_wr);
        verify(n_wr, 1'b0, 1'b1);

        // Random programs ending in HALT, then stray bytes after completion.
        for (int t = 0; t < 3; t++) begin
            do_reset();
            prog.delete();
            for (int i = 0; i < int'($urandom_range(1, 8)); i++) prog.push_back(rand_word(1'b0));
            prog.push_back(rand_word(1'b1));
            load_prog(1'b0, n_wr);
            verify(n_wr, 1'b0, 1'b1);
        end
        seen_wr   = wr_seq;
        seen_addr = Addr;
        for (int i = 0; i < 8; i++) send_byte(8'($urandom), 1'b0);
        tick(6);
        check("after_done_wr", wr_seq, seen_wr);
        check("after_done_addr", 32'(Addr), 32'(seen_addr));
        check("after_done_cpu", 32'(cpu_ena), 32'd1);

        // Memory fills without HALT.
        do_reset();
        prog.delete();
        for (int i = 0; i < 128; i++) prog.push_back(rand_word(1'b0));
        load_prog(1'b0, n_wr);
        verify(n_wr, 1'b1, 1'b1);
        check("ovf_addr", 32'(Addr), 32'd127);
        seen_wr = wr_seq;
        for (int i = 0; i < 8; i++) send_byte(8'($urandom), 1'b0);
        tick(6);
        check("ovf_no_more_wr", wr_seq, seen_wr);

        // Reset in the middle of a load, then a one-word reload.
        do_reset();
        prog = {rand_word(1'b0)};
        for (int k = 3; k >= 0; k--) send_byte(prog[0][k*8 +: 8], k == 0);
        send_byte(8'h12, 1'b0);
        send_byte(8'h34, 1'b0);
        tick(6);
        check("midload_wr", wr_seq, 1);
        do_reset();
        prog = {32'hFC000000};
        load_prog(1'b0, n_wr);
        verify(n_wr, 1'b0, 1'b1);

`ifdef LOADER_CHECKSUM_EN
        do_reset();
        prog = {32'hFC000000};
        load_prog(1'b1, n_wr);
        check("chk_bad_err", 32'(chk_err), 32'd1);
        check("chk_bad_cpu", 32'(cpu_ena), 32'd0);
        do_reset();
        load_prog(1'b0, n_wr);
        check("chk_good_err", 32'(chk_err), 32'd0);
        check("chk_good_cpu", 32'(cpu_ena), 32'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
